// File: rtl/tcu_sequencer_if.sv
// tcu_sequencer_if: decoder/IR-side signal bundle of the 6502 timing and interrupt sequencer.
// Sequencer inputs : i_rdy, i_last, i_nmi_n, i_irq_n, i_flag_i
// Sequencer outputs: o_tcu[2:0], o_sync, o_ir_load, o_force_brk, o_interrupt,
//                    o_res_seq, o_vector[1:0], o_jam
// slave modport is the sequencer itself; master is the surrounding core (or a bench).
interface tcu_sequencer_if;
    logic       i_rdy;
    logic       i_last;
    logic       i_nmi_n;
    logic       i_irq_n;
    logic       i_flag_i;
    logic [2:0] o_tcu;
    logic       o_sync;
    logic       o_ir_load;
    logic       o_force_brk;
    logic       o_interrupt;
    logic       o_res_seq;
    logic [1:0] o_vector;
    logic       o_jam;
    modport master (
        output i_rdy, i_last, i_nmi_n, i_irq_n, i_flag_i,
        input  o_tcu, o_sync, o_ir_load, o_force_brk, o_interrupt, o_res_seq, o_vector, o_jam
    );
    modport slave (
        input  i_rdy, i_last, i_nmi_n, i_irq_n, i_flag_i,
        output o_tcu, o_sync, o_ir_load, o_force_brk, o_interrupt, o_res_seq, o_vector, o_jam
    );
endinterface

// File: rtl/tcu_sequencer.sv
// tcu_sequencer: 6502 timing counter (T0..T6), instruction end handling and RES/NMI/IRQ arbitration.
// Ports: i_clk, i_reset (async, active high), bus (tcu_sequencer_if.slave):
//   i_rdy freezes all state, i_last ends the instruction, i_nmi_n/i_irq_n/i_flag_i interrupt inputs;
//   o_tcu/o_sync/o_ir_load timing, o_force_brk/o_interrupt/o_res_seq/o_vector interrupt entry,
//   o_jam counter overran T6.
// Optional feature macro: CPU6502_NMI_EN enables NMI edge detect, priority and vector hijack.
module tcu_sequencer (
    input  logic           i_clk,
    input  logic           i_reset,
    tcu_sequencer_if.slave bus
);
    localparam logic [1:0] VEC_IRQ = 2'b00;
    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_RES = 2'b10;
    logic [2:0] tcu;
    logic [1:0] vector;
    logic       jam, force_brk, interrupt, res_seq;
    logic       step, irq_req, nmi_take, nmi_hijack;
    // A jammed counter freezes the whole sequencer until reset.
    assign step    = bus.i_rdy & ~jam;
    assign irq_req = ~bus.i_irq_n & ~bus.i_flag_i;
`ifdef CPU6502_NMI_EN
    logic nmi_q, nmi_pending, nmi_edge, nmi_clr;
    assign nmi_edge   = nmi_q & ~bus.i_nmi_n;
    assign nmi_take   = nmi_pending;
    // An NMI arriving early in an IRQ sequence redirects its vector instead of queueing a second entry.
    assign nmi_hijack = (nmi_edge | nmi_pending) & interrupt & (vector == VEC_IRQ) & (tcu <= 3'd4);
    assign nmi_clr    = step & (bus.i_last ? nmi_pending : nmi_hijack);
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            nmi_q       <= 1'b1;
            nmi_pending <= 1'b0;
        end else if (bus.i_rdy) begin
            nmi_q       <= bus.i_nmi_n;
            nmi_pending <= nmi_clr ? 1'b0 : (nmi_pending | nmi_edge);
        end
    end
`else
    assign nmi_take   = 1'b0;
    assign nmi_hijack = 1'b0;
`endif
    // Reset itself is the forced T0 of the RES sequence, so no separate RES pending flag survives it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tcu       <= 3'd0;
            jam       <= 1'b0;
            force_brk <= 1'b1;
            interrupt <= 1'b1;
            res_seq   <= 1'b1;
            vector    <= VEC_RES;
        end else if (step) begin
            if (bus.i_last) begin
                tcu       <= 3'd0;
                force_brk <= nmi_take | irq_req;
                interrupt <= nmi_take | irq_req;
                res_seq   <= 1'b0;
                if (nmi_take | irq_req)
                    vector <= nmi_take ? VEC_NMI : VEC_IRQ;
            end else begin
                tcu       <= (tcu == 3'd6) ? 3'd7 : tcu + 3'd1;
                jam       <= (tcu == 3'd6);
                force_brk <= 1'b0;
                if (nmi_hijack)
                    vector <= VEC_NMI;
            end
        end
    end
    assign bus.o_tcu       = tcu;
    assign bus.o_sync      = (tcu == 3'd0);
    assign bus.o_ir_load   = (tcu == 3'd0) & bus.i_rdy & ~i_reset;
    assign bus.o_force_brk = force_brk;
    assign bus.o_interrupt = interrupt;
    assign bus.o_res_seq   = res_seq;
    assign bus.o_vector    = vector;
    assign bus.o_jam       = jam;
endmodule

// File: tb/tb_tcu_sequencer.sv
// tb_tcu_sequencer: scoreboard bench for tcu_sequencer; directed cases followed by random traffic.
module tb_tcu_sequencer;
`ifdef CPU6502_NMI_EN
    localparam bit NMI_EN = 1'b1;
`else
    localparam bit NMI_EN = 1'b0;
`endif
    typedef struct packed {
        logic [2:0] tcu;
        logic       sync;
        logic       ir_load;
        logic       force_brk;
        logic       interrupt;
        logic       res_seq;
        logic [1:0] vector;
        logic       jam;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    tcu_sequencer_if bus ();
    tcu_sequencer dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int       m_tcu;
    bit       m_jam, m_fb, m_int, m_res, m_nq, m_np;
    bit [1:0] m_vec;
    function automatic obs_t model_obs(input bit r);
        obs_t o;
        o.tcu       = 3'(m_tcu);
        o.sync      = (m_tcu == 0);
        o.ir_load   = (m_tcu == 0) && r;
        o.force_brk = m_fb;
        o.interrupt = m_int;
        o.res_seq   = m_res;
        o.vector    = m_vec;
        o.jam       = m_jam;
        return o;
    endfunction
    // Reference: what the sequencer must look like after one clock with these inputs.
    task automatic model_step(input bit r, input bit l, input bit nmi_n, input bit irq_n, input bit fi);
        bit fell;
        int winner;
        if (!r) return;
        fell = NMI_EN && m_nq && !nmi_n;
        m_nq = nmi_n;
        if (m_jam) begin
            m_np = m_np | fell;
            return;
        end
        if (l) begin
            winner = m_np ? 1 : (!irq_n && !fi) ? 2 : 0;
            m_np   = (winner == 1) ? 1'b0 : fell;
            m_tcu  = 0;
            m_fb   = (winner != 0);
            m_int  = (winner != 0);
            m_res  = 1'b0;
            if (winner == 1) m_vec = 2'b01;
            else if (winner == 2) m_vec = 2'b00;
        end else begin
            if ((fell || m_np) && m_int && m_vec == 2'b00 && m_tcu <= 4) begin
                m_vec = 2'b01;
                m_np  = 1'b0;
            end else begin
                m_np = m_np | fell;
            end
            m_fb = 1'b0;
            if (m_tcu == 6) begin
                m_tcu = 7;
                m_jam = 1'b1;
            end else begin
                m_tcu = m_tcu + 1;
            end
        end
    endtask
    // Drive one clock period starting just after a rising edge.
    task automatic cycle(input bit r, input bit l, input bit nmi_n, input bit irq_n, input bit fi);
        bus.i_rdy    = r;
        bus.i_last   = l;
        bus.i_nmi_n  = nmi_n;
        bus.i_irq_n  = irq_n;
        bus.i_flag_i = fi;
        exp_q.push_back(model_obs(r));
        model_step(r, l, nmi_n, irq_n, fi);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst          = 1'b1;
        bus.i_rdy    = 1'b1;
        bus.i_last   = 1'b0;
        bus.i_nmi_n  = 1'b1;
        bus.i_irq_n  = 1'b1;
        bus.i_flag_i = 1'b0;
        m_tcu = 0; m_jam = 0; m_fb = 1; m_int = 1; m_res = 1; m_vec = 2'b10; m_nq = 1; m_np = 0;
        exp_q.push_back({3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        cyc++;
        got = {bus.o_tcu, bus.o_sync, bus.o_ir_load, bus.o_force_brk, bus.o_interrupt,
               bus.o_res_seq, bus.o_vector, bus.o_jam};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs got tcu=%0d sync=%b irl=%b fbrk=%b int=%b res=%b vec=%b jam=%b required tcu=%0d sync=%b irl=%b fbrk=%b int=%b res=%b vec=%b jam=%b",
                         cyc, got.tcu, got.sync, got.ir_load, got.force_brk, got.interrupt, got.res_seq,
                         got.vector, got.jam, e.tcu, e.sync, e.ir_load, e.force_brk, e.interrupt,
                         e.res_seq, e.vector, e.jam);
            end
        end
    end
    initial begin : main
        int tgt;
        bit r, l, nmi_n, irq_n, fi;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, i == 6, 1, 1, 0);
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, i == 6, 1, 1, 0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, i == 6, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, i == 6, 1, 1, 0);
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, i == 6, (i >= 3) ? 1'b0 : 1'b1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        cycle(1, 1, 1, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 1, 0);
        do_reset();
        tgt = 6; nmi_n = 1; irq_n = 1; fi = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                do_reset();
                tgt = 6;
            end
            r = ($urandom_range(0, 99) < 85);
            l = (m_tcu == tgt);
            nmi_n = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 15) == 0) fi = ~fi;
            cycle(r, l, nmi_n, irq_n, fi);
            if (r && l) tgt = m_fb ? 6 : $urandom_range(0, 6);
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
